// File: rtl/edge_mask_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : edge_mask_packer_pkg
// Purpose : Shared widths, FSM states, FIFO entry type and popcount helper
// Rev     : 1.0  initial release
// ============================================================================
package edge_mask_packer_pkg;

    localparam int LANE_N         = 8;
    localparam int DWIDTH         = 8;
    localparam int WORD_W         = 32;
    localparam int BEATS_PER_WORD = WORD_W / LANE_N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } pack_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
        logic              eof;
    } fifo_entry_t;

    // Three-level adder tree over the eight mask lanes.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [1:0] p0, p1, p2, p3;
        logic [2:0] q0, q1;
        p0 = {1'b0, v[0]} + {1'b0, v[1]};
        p1 = {1'b0, v[2]} + {1'b0, v[3]};
        p2 = {1'b0, v[4]} + {1'b0, v[5]};
        p3 = {1'b0, v[6]} + {1'b0, v[7]};
        q0 = {1'b0, p0} + {1'b0, p1};
        q1 = {1'b0, p2} + {1'b0, p3};
        return {1'b0, q0} + {1'b0, q1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_mask_packer_if.sv
`default_nettype none
// ============================================================================
// Module  : edge_mask_packer_if
// Purpose : Valid/ready packed-word stream toward the frame writer
// Rev     : 1.0  initial release
// ============================================================================
interface edge_mask_packer_if;

    logic [edge_mask_packer_pkg::WORD_W-1:0] m_data;
    logic                                    m_vld;
    logic                                    m_rdy;
    logic                                    m_last;
    logic                                    m_eof;

    modport master (output m_data, m_vld, m_last, m_eof, input m_rdy);
    modport slave  (input m_data, m_vld, m_last, m_eof, output m_rdy);

endinterface
`default_nettype wire

// File: rtl/edge_mask_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module  : edge_word_fifo
// Purpose : First-word fall-through FIFO of packed words with last/eof tags
// Rev     : 1.0  initial release
// ============================================================================
module edge_word_fifo
    import edge_mask_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_wr,
    input  wire fifo_entry_t i_wdata,
    output      logic        o_full,
    input  wire logic        i_rd,
    output      fifo_entry_t o_rdata,
    output      logic        o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    fifo_entry_t    r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_pop;
    logic           w_push;

    assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_pop   = i_rd && !o_empty;
    assign w_push  = i_wr && (!o_full || w_pop);
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/edge_mask_packer.sv
`default_nettype none
// ============================================================================
// Module  : edge_mask_packer
// Purpose : Packs 8-lane edge-mask beats into row-aligned 32-bit words
// Rev     : 1.0  initial release
// ============================================================================
module edge_mask_packer
    import edge_mask_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic               sys_clk,
    input  wire logic               sys_rst_n,
    input  wire logic [31:0]        rowSize,
    input  wire logic [31:0]        colSize,
    input  wire logic               new_frame,
    input  wire logic [LANE_N-1:0]  mask_in,
    input  wire logic               mask_vld,
    edge_mask_packer_if.master      m_if,
    output      logic [15:0]        row_edge_cnt,
    output      logic [15:0]        row_idx,
    output      logic               row_cnt_vld,
    output      logic               overflow,
    output      logic               frame_done
);

    pack_state_t  r_state, w_state_nxt;
    logic         w_done_nxt;

    logic [15:0]  r_rows, r_row_cnt, r_edge_acc, r_pend_cnt, r_pend_idx;
    logic [12:0]  r_bpr, r_beat_cnt;
    logic [31:0]  r_pack;
    logic [1:0]   r_slot;
    logic         r_push, r_row_pend;
    fifo_entry_t  r_push_data, w_rd_data;
    logic         w_fifo_full, w_fifo_empty;

    wire w_unused = ^{rowSize[31:16], colSize[31:16], colSize[2:0]};

    wire        w_degenerate = (rowSize[15:0] == 16'd0) || (colSize[15:3] == 13'd0);
    wire        w_beat       = (r_state == ACTIVE) && mask_vld && !new_frame;
    wire        w_row_end    = w_beat && (r_beat_cnt == r_bpr - 13'd1);
    wire        w_frame_end  = w_row_end && (r_row_cnt == r_rows - 16'd1);
    wire        w_word_end   = w_beat && ((r_slot == 2'(BEATS_PER_WORD-1)) || w_row_end);
    wire [31:0] w_word       = r_pack | ({mask_in, 24'd0} >> {r_slot, 3'b000});
    wire [15:0] w_edge_sum   = r_edge_acc + 16'(popcount8(mask_in));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        if (new_frame) begin
            w_state_nxt = w_degenerate ? DRAIN : ACTIVE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                ACTIVE:  if (w_frame_end) w_state_nxt = DRAIN;
                // The pending push register must also be empty before the frame is drained.
                DRAIN: begin
                    if (w_fifo_empty && !r_push) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rows       <= '0;
            r_bpr        <= '0;
            r_beat_cnt   <= '0;
            r_row_cnt    <= '0;
            r_edge_acc   <= '0;
            r_pack       <= '0;
            r_slot       <= '0;
            r_push       <= 1'b0;
            r_push_data  <= '0;
            r_row_pend   <= 1'b0;
            r_pend_cnt   <= '0;
            r_pend_idx   <= '0;
            row_cnt_vld  <= 1'b0;
            row_edge_cnt <= '0;
            row_idx      <= '0;
            overflow     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            r_push      <= w_word_end;
            r_row_pend  <= w_row_end;
            row_cnt_vld <= r_row_pend;
            frame_done  <= w_done_nxt;
            if (w_word_end) begin
                r_push_data <= '{data: w_word, last: w_row_end, eof: w_frame_end};
            end
            if (r_row_pend) begin
                row_edge_cnt <= r_pend_cnt;
                row_idx      <= r_pend_idx;
            end
            if (r_push && w_fifo_full && !m_if.m_rdy) overflow <= 1'b1;

            if (new_frame) begin
                r_rows     <= rowSize[15:0];
                r_bpr      <= colSize[15:3];
                r_beat_cnt <= '0;
                r_row_cnt  <= '0;
                r_edge_acc <= '0;
                r_pack     <= '0;
                r_slot     <= '0;
                overflow   <= 1'b0;
            end else if (w_beat) begin
                r_pack <= w_word_end ? 32'd0 : w_word;
                r_slot <= w_word_end ? 2'd0 : r_slot + 2'd1;
                if (w_row_end) begin
                    r_beat_cnt <= '0;
                    r_row_cnt  <= r_row_cnt + 16'd1;
                    r_edge_acc <= '0;
                    r_pend_cnt <= w_edge_sum;
                    r_pend_idx <= r_row_cnt;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 13'd1;
                    r_edge_acc <= w_edge_sum;
                end
            end
        end
    end

    edge_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .i_wr    (r_push),
        .i_wdata (r_push_data),
        .o_full  (w_fifo_full),
        .i_rd    (m_if.m_rdy),
        .o_rdata (w_rd_data),
        .o_empty (w_fifo_empty)
    );

    assign m_if.m_vld  = !w_fifo_empty;
    assign m_if.m_data = w_rd_data.data;
    assign m_if.m_last = w_rd_data.last;
    assign m_if.m_eof  = w_rd_data.eof;

endmodule
`default_nettype wire

// File: tb/tb_edge_mask_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_edge_mask_packer
// Purpose : Directed and randomized frames checked against a stream model
// Rev     : 1.0  initial release
// ============================================================================
module tb_edge_mask_packer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] rowSize = '0;
    logic [31:0] colSize = '0;
    logic        new_frame = 1'b0;
    logic [7:0]  mask_in = '0;
    logic        mask_vld = 1'b0;
    logic [15:0] row_edge_cnt, row_idx;
    logic        row_cnt_vld, overflow, frame_done;

    edge_mask_packer_if bus();

    edge_mask_packer #(.FIFO_DEPTH(4)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rowSize      (rowSize),
        .colSize      (colSize),
        .new_frame    (new_frame),
        .mask_in      (mask_in),
        .mask_vld     (mask_vld),
        .m_if         (bus),
        .row_edge_cnt (row_edge_cnt),
        .row_idx      (row_idx),
        .row_cnt_vld  (row_cnt_vld),
        .overflow     (overflow),
        .frame_done   (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int          errors = 0;
    int          checks = 0;
    int          n_done = 0;
    logic [7:0]  bq [$];
    logic [33:0] got_w [$];
    logic [33:0] exp_w [$];
    logic [31:0] got_r [$];
    logic [31:0] exp_r [$];

    always @(negedge sys_clk) begin
        if (bus.m_vld && bus.m_rdy) got_w.push_back({bus.m_data, bus.m_last, bus.m_eof});
        if (row_cnt_vld)            got_r.push_back({row_edge_cnt, row_idx});
        if (frame_done)             n_done++;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream model: beat i lands in row i/bpr at column-beat i%bpr.
    task automatic model(input int rows, input int cols, input int nb);
        int          bpr;
        int          cnt;
        logic [31:0] word;
        bpr  = (cols & 32'hFFFF) >> 3;
        rows = rows & 32'hFFFF;
        cnt  = 0;
        word = '0;
        if (rows == 0 || bpr == 0) return;
        for (int i = 0; i < nb; i++) begin
            int   row;
            int   pos;
            int   slot;
            logic lastw;
            row  = i / bpr;
            pos  = i % bpr;
            slot = pos % 4;
            if (row >= rows) break;
            word  = word | (32'(bq[i]) << (24 - 8 * slot));
            cnt  += $countones(bq[i]);
            lastw = (pos == bpr - 1);
            if (slot == 3 || lastw) begin
                exp_w.push_back({word, lastw, lastw && (row == rows - 1)});
                word = '0;
            end
            if (lastw) begin
                exp_r.push_back({16'(cnt), 16'(row)});
                cnt = 0;
            end
        end
    endtask

    task automatic start_frame(input logic [31:0] rows, input logic [31:0] cols);
        new_frame = 1'b1;
        rowSize   = rows;
        colSize   = cols;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic send(input int first, input int nb, input int gap);
        for (int i = first; i < first + nb; i++) begin
            repeat ($urandom_range(0, gap)) begin
                mask_vld = 1'b0;
                mask_in  = 8'($urandom);
                tick();
            end
            mask_in  = bq[i];
            mask_vld = 1'b1;
            tick();
        end
        mask_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start;
        int k;
        start = n_done;
        for (k = 0; k < 400 && n_done == start; k++) tick();
        check({tag, "_frame_done"}, 64'(n_done - start), 64'd1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_nwords"}, 64'(got_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 64'(got_w[i]), 64'(exp_w[i]));
        check({tag, "_nrows"}, 64'(got_r.size()), 64'(exp_r.size()));
        for (int i = 0; i < exp_r.size() && i < got_r.size(); i++)
            check($sformatf("%s_row%0d", tag, i), 64'(got_r[i]), 64'(exp_r[i]));
        got_w.delete(); exp_w.delete(); got_r.delete(); exp_r.delete();
    endtask

    initial begin
        bus.m_rdy = 1'b1;
        repeat (3) tick();
        check("rst_m_vld", 64'(bus.m_vld), 64'd0);
        check("rst_m_data", 64'(bus.m_data), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_row_cnt_vld", 64'(row_cnt_vld), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        sys_rst_n = 1'b1;
        tick();

        // Two-row frame of one word each
        bq = '{8'hFF, 8'h00, 8'h81, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        model(2, 32, 8);
        start_frame(2, 32);
        send(0, 8, 0);
        wait_done("t1");
        if (got_w.size() > 0) check("t1_word0_const", 64'(got_w[0]), {30'd0, 32'hFF008101, 2'b10});
        if (got_r.size() > 0) check("t1_row0_const", 64'(got_r[0]), {32'd0, 16'd11, 16'd0});
        compare("t1");

        // Partial last word is zero padded
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        model(1, 48, 6);
        start_frame(1, 48);
        send(0, 6, 2);
        wait_done("t2");
        if (got_w.size() > 1) check("t2_word1_const", 64'(got_w[1]), {30'd0, 32'h55660000, 2'b11});
        compare("t2");

        // One-beat rows
        bq = '{8'h80, 8'h03, 8'hFF};
        model(3, 8, 3);
        start_frame(3, 8);
        send(0, 3, 1);
        wait_done("t3");
        compare("t3");

        // Latency: beat at edge N, word visible and row count pulse after N+1
        bus.m_rdy = 1'b0;
        bq = '{8'hA5};
        model(1, 8, 1);
        start_frame(1, 8);
        mask_in  = 8'hA5;
        mask_vld = 1'b1;
        tick();
        mask_vld = 1'b0;
        check("lat_m_vld_N", 64'(bus.m_vld), 64'd0);
        tick();
        check("lat_m_vld_N1", 64'(bus.m_vld), 64'd1);
        check("lat_m_data_N1", 64'(bus.m_data), 64'hA5000000);
        check("lat_row_vld_N1", 64'(row_cnt_vld), 64'd1);
        check("lat_row_cnt_N1", 64'(row_edge_cnt), 64'd4);
        tick();
        check("lat_row_vld_N2", 64'(row_cnt_vld), 64'd0);
        check("lat_hold_data", 64'(bus.m_data), 64'hA5000000);
        check("lat_hold_eof", 64'(bus.m_eof), 64'd1);
        bus.m_rdy = 1'b1;
        wait_done("lat");
        compare("lat");

        // Overflow: five words into a four-entry FIFO with no reader
        bus.m_rdy = 1'b0;
        bq.delete();
        for (int i = 0; i < 20; i++) bq.push_back(8'($urandom));
        model(1, 160, 20);
        void'(exp_w.pop_back());
        start_frame(1, 160);
        send(0, 20, 0);
        repeat (3) tick();
        check("ovf_set", 64'(overflow), 64'd1);
        bus.m_rdy = 1'b1;
        wait_done("ovf");
        check("ovf_sticky", 64'(overflow), 64'd1);
        compare("ovf");

        // Degenerate size: done two cycles after new_frame, overflow cleared
        start_frame(0, 32);
        check("deg_overflow_clr", 64'(overflow), 64'd0);
        check("deg_done_early", 64'(frame_done), 64'd0);
        tick();
        check("deg_done_pulse", 64'(frame_done), 64'd1);
        tick();
        check("deg_done_end", 64'(frame_done), 64'd0);

        // Abort after two beats of row 1; row-0 word stays in the FIFO
        bus.m_rdy = 1'b0;
        bq.delete();
        for (int i = 0; i < 10; i++) bq.push_back(8'($urandom));
        model(2, 32, 6);
        start_frame(2, 32);
        send(0, 6, 0);
        bq = bq[6:9];
        model(1, 32, 4);
        start_frame(1, 32);
        send(0, 4, 1);
        tick();
        bus.m_rdy = 1'b1;
        wait_done("abort");
        compare("abort");

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            int rows;
            int cols;
            int nb;
            rows = $urandom_range(1, 4);
            cols = $urandom_range(8, 80);
            nb   = rows * (cols / 8);
            bq.delete();
            for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
            model(rows, cols, nb);
            start_frame(32'(rows), {16'($urandom), 16'(cols)});
            send(0, nb, 2);
            wait_done($sformatf("rnd%0d", f));
            check($sformatf("rnd%0d_overflow", f), 64'(overflow), 64'd0);
            compare($sformatf("rnd%0d", f));
        end

        // Asynchronous reset with a word waiting
        bus.m_rdy = 1'b0;
        bq = '{8'h0F, 8'hF0, 8'h3C, 8'hC3};
        start_frame(2, 32);
        send(0, 4, 0);
        tick();
        check("arst_pre_vld", 64'(bus.m_vld), 64'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_m_vld", 64'(bus.m_vld), 64'd0);
        check("arst_m_data", 64'(bus.m_data), 64'd0);
        check("arst_m_last", 64'(bus.m_last), 64'd0);
        check("arst_row_cnt", 64'(row_edge_cnt), 64'd0);
        tick();
        sys_rst_n = 1'b1;
        bus.m_rdy = 1'b1;
        got_w.delete();
        got_r.delete();
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send(0, 8, 0);
        repeat (4) tick();
        check("arst_ignore_vld", 64'(bus.m_vld), 64'd0);
        check("arst_ignore_words", 64'(got_w.size()), 64'd0);
        check("arst_ignore_rows", 64'(got_r.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
